// File: rtl/clkdiv_rst_seq_pkg.sv
// Shared types and constants for the programmable clock divider / reset sequencer.
// Package name is clkdiv_pkg; all rtl files import it.
package clkdiv_pkg;

   // Width of a channel index: $clog2 with a floor of 1 bit.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int HOLD_W = 4;

   // Divisor presets for the two clock families.
   localparam int DIV_48M = 1;
   localparam int DIV_96M = 0;

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2
   } rst_st_e;

endpackage

// File: rtl/clkdiv_rst_seq_if.sv
// Divisor configuration port: valid/ready request plus an invalid-channel error pulse.
interface clkdiv_rst_seq_if #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 4
);
   import clkdiv_pkg::*;
   localparam int CH_W = ch_w(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_err;

   modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_rst_seq_chan.sv
// One divider channel: phase counter, divisor register with a single pending slot,
// and the ARMED/HOLD/RUN reset sequencer that advances on div_clk falling edges.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int DIV_W     = 4,
   parameter int DIV_RESET = 1,
   parameter int RST_HOLD  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_div_i,
   output logic             pend_o,
   output logic             div_clk_o,
   output logic             div_stb_o,
   output logic             dom_rst_o,
   output logic             dom_ready_o
);

   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, pdiv_q;
   logic              pend_q, clk_q, stb_q, drst_q, rdy_q;
   logic [HOLD_W-1:0] hold_q;
   rst_st_e           st_q;
   logic              wrap, fall;

   always_comb begin
      wrap  = ena_i && (cnt_q == div_q);
      fall  = wrap && clk_q;
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         div_q  <= DIV_W'(DIV_RESET);
         pdiv_q <= '0;
         pend_q <= 1'b0;
         clk_q  <= 1'b0;
         stb_q  <= 1'b0;
         drst_q <= 1'b0;
         rdy_q  <= 1'b0;
         hold_q <= '0;
         st_q   <= ST_ARMED;
      end else begin
         stb_q <= wrap && !clk_q;
         if (ena_i) cnt_q <= cnt_d;
         if (wrap) clk_q <= !clk_q;
         // wr_i is only granted while no update is pending, so it never collides with the apply.
         if (wr_i) begin
            pend_q <= 1'b1;
            pdiv_q <= wr_div_i;
         end
         if (fall && pend_q) begin
            div_q  <= pdiv_q;
            pend_q <= 1'b0;
         end
         if (fall) begin
            unique case (st_q)
               ST_ARMED: begin
                  drst_q <= 1'b1;
                  hold_q <= HOLD_W'(RST_HOLD - 1);
                  st_q   <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (hold_q != '0) begin
                     hold_q <= hold_q - 1'b1;
                  end else begin
                     drst_q <= 1'b0;
                     rdy_q  <= 1'b1;
                     st_q   <= ST_RUN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pend_o      = pend_q;
   assign div_clk_o   = clk_q;
   assign div_stb_o   = stb_q;
   assign dom_rst_o   = drst_q;
   assign dom_ready_o = rdy_q;

endmodule

// File: rtl/clkdiv_rst_seq.sv
// Multi-channel programmable clock divider with per-domain reset sequencing.
// Decodes config requests onto channels and reports accepts to nonexistent channels.
module clkdiv_rst_seq
   import clkdiv_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DIV_W     = 4,
   parameter int DIV_RESET = 1,
   parameter int RST_HOLD  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   clkdiv_rst_seq_if.slave   cfg,
   output logic [NUM_CH-1:0] div_clk,
   output logic [NUM_CH-1:0] div_stb,
   output logic [NUM_CH-1:0] dom_rst,
   output logic [NUM_CH-1:0] dom_ready
);

   localparam int CH_W = ch_w(NUM_CH);

   logic [NUM_CH-1:0] pend, wr;
   logic              ch_ok, ready, accept;
   logic              err_q;

   always_comb begin
      ch_ok  = 32'(cfg.cfg_ch) < 32'(NUM_CH);
      ready  = 1'b1;
      wr     = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (cfg.cfg_ch == CH_W'(i)) ready = !pend[i];
      accept = cfg.cfg_valid && ready;
      for (int i = 0; i < NUM_CH; i++)
         wr[i] = accept && (cfg.cfg_ch == CH_W'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= accept && !ch_ok;
   end

   assign cfg.cfg_ready = ready;
   assign cfg.cfg_err   = err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_chan #(
         .DIV_W     (DIV_W),
         .DIV_RESET (DIV_RESET),
         .RST_HOLD  (RST_HOLD)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .ena_i       (ena),
         .wr_i        (wr[g]),
         .wr_div_i    (cfg.cfg_div),
         .pend_o      (pend[g]),
         .div_clk_o   (div_clk[g]),
         .div_stb_o   (div_stb[g]),
         .dom_rst_o   (dom_rst[g]),
         .dom_ready_o (dom_ready[g])
      );
   end

endmodule

// File: tb/tb_clkdiv_rst_seq.sv
// Randomized check of clkdiv_rst_seq against a phase-length / falling-edge-count model.
// Three channels with a 2-bit index so that index 3 is a reachable invalid channel.
module tb_clkdiv_rst_seq;
   localparam int NCH  = 3;
   localparam int DW   = 4;
   localparam int DRST = 1;
   localparam int HOLD = 2;

   logic clk, rst, ena;
   logic [NCH-1:0] div_clk, div_stb, dom_rst, dom_ready;
   int n_chk = 0, n_err = 0;

   clkdiv_rst_seq_if #(.NUM_CH(NCH), .DIV_W(DW)) cif ();

   clkdiv_rst_seq #(.NUM_CH(NCH), .DIV_W(DW), .DIV_RESET(DRST), .RST_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .ena(ena), .cfg(cif),
      .div_clk(div_clk), .div_stb(div_stb), .dom_rst(dom_rst), .dom_ready(dom_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Model: remaining cycles in the current phase, output level, and the number of
   // falling edges seen since reset (which alone determines dom_rst/dom_ready).
   int rem[NCH], mdiv[NCH], mpdiv[NCH], nfall[NCH];
   bit lvl[NCH], mpend[NCH], mstb[NCH];
   bit merr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void mreset();
      for (int i = 0; i < NCH; i++) begin
         rem[i] = DRST + 1; mdiv[i] = DRST; mpdiv[i] = 0; nfall[i] = 0;
         lvl[i] = 0; mpend[i] = 0; mstb[i] = 0;
      end
      merr = 0;
   endfunction

   function automatic bit exp_ready(input int ch);
      return (ch >= NCH) ? 1'b1 : !mpend[ch];
   endfunction

   function automatic void madvance(input bit acc, input int ch, input int dv, input bit en);
      merr = acc && (ch >= NCH);
      for (int i = 0; i < NCH; i++) begin
         mstb[i] = 0;
         if (en) begin
            rem[i]--;
            if (rem[i] == 0) begin
               lvl[i] = !lvl[i];
               if (lvl[i]) mstb[i] = 1;
               else begin
                  if (nfall[i] <= HOLD) nfall[i]++;
                  if (mpend[i]) begin mdiv[i] = mpdiv[i]; mpend[i] = 0; end
               end
               rem[i] = mdiv[i] + 1;
            end
         end
      end
      if (acc && ch < NCH) begin mpend[ch] = 1; mpdiv[ch] = dv; end
   endfunction

   task automatic chk_out();
      logic [NCH-1:0] e_clk, e_stb, e_rst, e_rdy;
      for (int i = 0; i < NCH; i++) begin
         e_clk[i] = lvl[i];
         e_stb[i] = mstb[i];
         e_rst[i] = (nfall[i] >= 1) && (nfall[i] <= HOLD);
         e_rdy[i] = nfall[i] > HOLD;
      end
      chk("div_clk", 32'(div_clk), 32'(e_clk));
      chk("div_stb", 32'(div_stb), 32'(e_stb));
      chk("dom_rst", 32'(dom_rst), 32'(e_rst));
      chk("dom_ready", 32'(dom_ready), 32'(e_rdy));
      chk("cfg_err", 32'(cif.cfg_err), 32'(merr));
   endtask

   // Called at a negedge: drive, check ready, advance model, run one clk edge, check outputs.
   task automatic step(input bit v, input int ch, input int dv, input bit en, input bit r);
      bit acc;
      cif.cfg_valid = v; cif.cfg_ch = 2'(ch); cif.cfg_div = 4'(dv);
      ena = en; rst = r;
      #1;
      if (r) begin mreset(); chk_out(); end
      chk("cfg_ready", 32'(cif.cfg_ready), 32'(exp_ready(ch)));
      acc = v && exp_ready(ch);
      if (!r) madvance(acc, ch, dv, en);
      @(posedge clk);
      @(negedge clk);
      chk_out();
   endtask

   initial begin
      int k;
      rst = 1'b1; ena = 1'b0;
      cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_div = '0;
      mreset();
      @(negedge clk);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);

      // Defaults: period 4, dom_rst over cycles 4..11, ready from 12.
      for (k = 1; k <= 16; k++) begin
         step(0, 0, 0, 1, 0);
         chk("dir_dclk", 32'(div_clk[0]), 32'(((k / 2) % 2) == 1));
         chk("dir_stb", 32'(div_stb[0]), 32'((k % 4) == 2));
         chk("dir_drst", 32'(dom_rst[0]), 32'((k >= 4) && (k < 12)));
         chk("dir_drdy", 32'(dom_ready[0]), 32'(k >= 12));
      end

      // Reprogram ch0 during its high phase.
      for (k = 0; k < 10 && !lvl[0]; k++) step(0, 0, 0, 1, 0);
      step(1, 0, 3, 1, 0);
      repeat (20) step(0, 0, 0, 1, 0);

      // Back-to-back to ch1: the second request stalls until the first applies.
      step(1, 1, 0, 1, 0);
      for (k = 0; k < 20 && !exp_ready(1); k++) step(1, 1, 2, 1, 0);
      step(1, 1, 2, 1, 0);
      repeat (24) step(0, 0, 0, 1, 0);

      // Invalid channel: single-cycle error, no divisor change.
      step(1, 3, 5, 1, 0);
      chk("dir_err1", 32'(cif.cfg_err), 32'd1);
      step(0, 0, 0, 1, 0);
      chk("dir_err0", 32'(cif.cfg_err), 32'd0);

      // ena low for 5 cycles during HOLD.
      step(0, 0, 0, 1, 1);
      for (k = 0; k < 20 && nfall[0] == 0; k++) step(0, 0, 0, 1, 0);
      repeat (5) step(1, 2, 1, 0, 0);
      repeat (20) step(0, 0, 0, 1, 0);

      // Reset with a pending update on ch0.
      step(1, 0, 4, 1, 0);
      step(0, 0, 0, 1, 1);
      repeat (20) step(0, 0, 0, 1, 0);

      repeat (3000) begin
         step($urandom_range(2) == 0, int'($urandom_range(3)), int'($urandom_range(5)),
              $urandom_range(9) != 0, $urandom_range(499) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
